pe_weight_fetch: RTL and testbench

//   Upstream weight feeder for the PE column: on a start pulse it streams NUM words from the

---
 rtl/pe_weight_fetch_if.sv | 32 +++
 rtl/pe_weight_fetch.sv | 157 +++++++++++++++
 tb/tb_pe_weight_fetch.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_weight_fetch_if.sv
// Handshake/data bundle between a job controller, the weight SRAM and the PE weight port.
// slave is the fetch engine's view; master is the surrounding system (controller, SRAM, PE).
// Widths follow the engine parameters so both sides agree on bus sizes.
interface pe_weight_fetch_if #(
  parameter int D_W    = 64,
  parameter int ADDR_W = 14
);
  // job request / status
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_words;
  logic              busy;
  logic              done;
  // weight SRAM read port
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [D_W-1:0]    mem_rdata;
  // weight stream to the PE
  logic [D_W-1:0]    w_data;
  logic              w_valid;
  logic              w_ready;

  modport slave (
    input  start, base_addr, num_words, mem_rdata, w_ready,
    output busy, done, mem_en, mem_addr, w_data, w_valid
  );

  modport master (
    output start, base_addr, num_words, mem_rdata, w_ready,
    input  busy, done, mem_en, mem_addr, w_data, w_valid
  );
endinterface

// File: rtl/pe_weight_fetch.sv
// Streams num_words weights from SRAM (base_addr upward, wrapping) into a PE via a prefetch FIFO.
// Latency: start cycle 0 -> mem_en cycle 1 -> w_valid cycle 3; 1 word/cycle sustained.
// Backpressure: w_ready low stalls pops; reads are credit-limited so the FIFO never overflows.
module pe_weight_fetch #(
  parameter int D_W        = 64,
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  pe_weight_fetch_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W:0]   remaining_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;

  logic [D_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic              pop;
  logic              issue;
  logic              accept;
  logic              last_issue;
  logic              last_pop;
  logic [CW:0]       occupancy;

  // The FIFO head is what the PE sees; a pop is any accepted transfer.
  assign pop = (count_q != '0) && bus.w_ready;

  // Slots committed after this cycle: stored words plus the read returning now,
  // minus the word leaving now. A new read is only issued if a slot remains for it.
  assign occupancy = {1'b0, count_q}
                   + {{CW{1'b0}}, inflight_q}
                   - {{CW{1'b0}}, pop};

  assign issue = (state_q == S_FETCH) && (remaining_q != '0) && (occupancy < DEPTH_V);

  assign accept     = (state_q == S_IDLE) && bus.start;
  assign last_issue = issue && (remaining_q == (ADDR_W + 1)'(1));
  // Only word left anywhere in the pipe is leaving this cycle.
  assign last_pop   = pop && (count_q == CW'(1)) && !inflight_q;

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.mem_en   = issue;
  assign bus.mem_addr = addr_q;
  assign bus.w_valid  = (count_q != '0);
  // Gate the head so an empty FIFO shows zero instead of stale storage.
  assign bus.w_data   = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job sequencing; start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.num_words == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        // With a one-cycle SRAM the final pop trails the final issue by at least two
        // cycles, so the pipe can only be empty here if it is being emptied right now.
        if (last_issue) begin
          state_d = S_DRAIN;
        end else if ((remaining_q == '0) && (last_pop || (count_q == '0 && !inflight_q))) begin
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Job counters: words still to request and the next SRAM address (wraps naturally).
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      addr_q      <= '0;
    end else if (accept) begin
      remaining_q <= bus.num_words;
      addr_q      <= bus.base_addr;
    end else if (issue) begin
      remaining_q <= remaining_q - (ADDR_W + 1)'(1);
      addr_q      <= addr_q + ADDR_W'(1);
    end
  end

  // Marks the SRAM data returning next cycle; cleared by reset so a read
  // issued before an abort is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (inflight_q) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + {{PW{1'b0}}, inflight_q} - {{PW{1'b0}}, pop};
    end
  end

  // FIFO storage captures SRAM data at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (inflight_q && !rst) begin
      fifo_mem[wr_ptr_q] <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_pe_weight_fetch.sv
module tb_pe_weight_fetch;

  logic clk;
  logic rst;

  pe_weight_fetch_if #(.D_W(64), .ADDR_W(14)) bus ();

  pe_weight_fetch #(.D_W(64), .ADDR_W(14), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight SRAM model: one-cycle read; garbage on the bus when not enabled.
  logic [63:0] sram [0:16383];
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_en ? sram[bus.mem_addr] : {$urandom, $urandom};
  end

  int tests_run = 0;
  int tests_failed = 0;

  // Observations collected by run_job (filled in, never compared there).
  logic [63:0] got_q [$];
  logic [63:0] exp_q [$];
  logic [13:0] addr_q [$];
  int          xfer_q [$];
  int first_valid, done_cyc, done_cnt, busy_cnt, busy_after;
  int memen_cnt, memen_pre, max_outst, stab_err;

  // Reference: the job delivers mem[base + i mod 2^14] for i in 0..num-1, in order.
  task automatic build_exp(input logic [13:0] base, input int num);
    exp_q.delete();
    for (int i = 0; i < num; i++) exp_q.push_back(sram[14'(int'(base) + i)]);
  endtask

  // Drives one job (start in cycle 0) and records what the DUT does, cycle by cycle.
  task automatic run_job(input logic [13:0] base, input logic [14:0] num, input int ready_pct,
                         input int release_at, input int restart_at, input int max_cyc);
    bit          hold_prev;
    logic [63:0] data_prev;
    int          outst;
    got_q.delete(); addr_q.delete(); xfer_q.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_after = -1;
    memen_cnt = 0; memen_pre = 0; max_outst = 0; stab_err = 0;
    hold_prev = 1'b0; data_prev = '0; outst = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.start = (c == 0) || (c == restart_at);
      if (c == 0) begin
        bus.base_addr = base;
        bus.num_words = num;
      end else if (c == restart_at) begin
        bus.base_addr = base + 14'd5;
        bus.num_words = 15'd3;
      end else begin
        bus.base_addr = 14'($urandom);
        bus.num_words = 15'($urandom);
      end
      if (release_at >= 0 && c < release_at) bus.w_ready = 1'b0;
      else if (ready_pct >= 100)             bus.w_ready = 1'b1;
      else                                   bus.w_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (hold_prev && (!bus.w_valid || bus.w_data !== data_prev)) stab_err++;
      hold_prev = bus.w_valid && !bus.w_ready;
      data_prev = bus.w_data;
      if (bus.mem_en) begin
        memen_cnt++;
        outst++;
        addr_q.push_back(bus.mem_addr);
        if (release_at >= 0 && c < release_at) memen_pre++;
      end
      if (bus.w_valid && first_valid < 0) first_valid = c;
      if (bus.w_valid && bus.w_ready) begin
        got_q.push_back(bus.w_data);
        xfer_q.push_back(c);
        outst--;
      end
      if (outst > max_outst) max_outst = outst;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = bus.busy;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_words = '0; bus.w_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests_run++; if (bus.mem_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en got %b want 0", bus.mem_en); end
    tests_run++; if (bus.w_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_w_valid got %b want 0", bus.w_valid); end
    tests_run++; if (bus.mem_addr !== 14'h0) begin tests_failed++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    tests_run++; if (bus.w_data !== 64'h0) begin tests_failed++; $display("FAIL reset_w_data got %h want 0", bus.w_data); end
  endtask

  task automatic test_basic;
    int bad;
    run_job(14'h0010, 15'd8, 100, -1, -1, 100);
    build_exp(14'h0010, 8);
    tests_run++; if (first_valid != 3) begin tests_failed++; $display("FAIL basic_first_valid got %0d want 3", first_valid); end
    tests_run++; if (got_q.size() != 8) begin tests_failed++; $display("FAIL basic_count got %0d want 8", got_q.size()); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 8; i++) if (got_q[i] !== exp_q[i] || xfer_q[i] != 3 + i) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL basic_data_order got %0d bad words want 0", bad); end
    tests_run++; if (done_cyc != 11) begin tests_failed++; $display("FAIL basic_done_cycle got %0d want 11", done_cyc); end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    tests_run++; if (busy_after != 0) begin tests_failed++; $display("FAIL basic_busy_after got %0d want 0", busy_after); end
    tests_run++; if (busy_cnt != 11) begin tests_failed++; $display("FAIL basic_busy_cycles got %0d want 11", busy_cnt); end
  endtask

  task automatic test_empty;
    run_job(14'h0123, 15'd0, 100, -1, -1, 50);
    tests_run++; if (memen_cnt != 0) begin tests_failed++; $display("FAIL empty_mem_en got %0d want 0", memen_cnt); end
    tests_run++; if (done_cyc != 1) begin tests_failed++; $display("FAIL empty_done_cycle got %0d want 1", done_cyc); end
    tests_run++; if (busy_cnt != 1) begin tests_failed++; $display("FAIL empty_busy_cycles got %0d want 1", busy_cnt); end
    tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL empty_words got %0d want 0", got_q.size()); end
  endtask

  task automatic test_backpressure;
    int bad;
    run_job(14'h0200, 15'd16, 100, 20, -1, 200);
    build_exp(14'h0200, 16);
    tests_run++; if (memen_pre != 4) begin tests_failed++; $display("FAIL bp_reads_while_stalled got %0d want 4", memen_pre); end
    tests_run++; if (max_outst != 4) begin tests_failed++; $display("FAIL bp_max_outstanding got %0d want 4", max_outst); end
    tests_run++; if (got_q.size() != 16) begin tests_failed++; $display("FAIL bp_count got %0d want 16", got_q.size()); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 16; i++) if (got_q[i] !== exp_q[i]) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL bp_data got %0d bad words want 0", bad); end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap;
    int bad;
    logic [13:0] want_addr [4];
    want_addr[0] = 14'h3FFE; want_addr[1] = 14'h3FFF; want_addr[2] = 14'h0000; want_addr[3] = 14'h0001;
    run_job(14'h3FFE, 15'd4, 100, -1, -1, 50);
    build_exp(14'h3FFE, 4);
    tests_run++; if (addr_q.size() != 4) begin tests_failed++; $display("FAIL wrap_reads got %0d want 4", addr_q.size()); end
    bad = 0;
    for (int i = 0; i < addr_q.size() && i < 4; i++) if (addr_q[i] !== want_addr[i]) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL wrap_addr got %0d bad addresses want 0", bad); end
    bad = (got_q.size() == 4) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < 4; i++) if (got_q[i] !== exp_q[i]) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL wrap_data got %0d errors want 0", bad); end
  endtask

  task automatic test_random;
    int bad, num, restart;
    logic [13:0] base;
    for (int it = 0; it < 4; it++) begin
      num     = (it == 0) ? 100 : $urandom_range(40, 1);
      base    = 14'($urandom);
      restart = (it == 0) ? 10 : $urandom_range(20, 2);
      run_job(base, 15'(num), 50, -1, restart, 3000);
      build_exp(base, num);
      tests_run++; if (done_cyc < 0) begin tests_failed++; $display("FAIL rand%0d_timeout got no done want done", it); end
      tests_run++; if (got_q.size() != num) begin tests_failed++; $display("FAIL rand%0d_count got %0d want %0d", it, got_q.size(), num); end
      bad = 0;
      for (int i = 0; i < got_q.size() && i < num; i++) if (got_q[i] !== exp_q[i]) bad++;
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL rand%0d_data got %0d bad words want 0", it, bad); end
      tests_run++; if (max_outst > 4) begin tests_failed++; $display("FAIL rand%0d_overflow got %0d outstanding want <=4", it, max_outst); end
      tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL rand%0d_stable got %0d changes want 0", it, stab_err); end
      tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL rand%0d_done_count got %0d want 1", it, done_cnt); end
    end
  endtask

  task automatic test_reset_midjob;
    int bad, stray;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 14'h0400; bus.num_words = 15'd20; bus.w_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    // cycle 4: two words stored, a third read returning, a fourth being issued
    tests_run++; if (bus.w_valid !== 1'b1 || bus.mem_en !== 1'b1) begin
      tests_failed++; $display("FAIL abort_pre got valid=%b mem_en=%b want 1 1", bus.w_valid, bus.mem_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (bus.w_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL abort_post got valid=%b mem_en=%b done=%b busy=%b want 0 0 0 0",
                               bus.w_valid, bus.mem_en, bus.done, bus.busy); end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.w_valid || bus.mem_en) stray++;
    end
    tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL abort_quiet got %0d active cycles want 0", stray); end
    run_job(14'h0800, 15'd6, 100, -1, -1, 100);
    build_exp(14'h0800, 6);
    bad = (got_q.size() == 6) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < 6; i++) if (got_q[i] !== exp_q[i]) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL abort_newjob_data got %0d errors want 0", bad); end
    tests_run++; if (first_valid != 3) begin tests_failed++; $display("FAIL abort_newjob_first got %0d want 3", first_valid); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = {$urandom, $urandom};
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
